// File: rtl/quarter_wave_arcsine.sv
// Arcsine by binary search over a quarter-wave sine table; the table is built at elaboration.
// Optional nearest-entry rounding stage: define QUARTER_WAVE_ARCSINE_ROUND_EN.
module quarter_wave_arcsine #(
    parameter int unsigned OW = 16,
    parameter int unsigned PW = 12
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_ce,
    input  logic          i_valid,
    input  logic [OW:0]   i_val,
    output logic          o_busy,
    output logic          o_valid,
    output logic [PW-1:0] o_phase
);

    localparam int unsigned AW    = PW - 2;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned BW    = $clog2(AW);
`ifdef QUARTER_WAVE_ARCSINE_ROUND_EN
    localparam logic [AW-1:0] KMAX = AW'(DEPTH - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CMP
`ifdef QUARTER_WAVE_ARCSINE_ROUND_EN
        , RREAD,
        RCMP
`endif
    } state_t;

    // Monotone sine-shaped curve x*(3-x^2)/2 sampled at bin centres, full scale 2^OW-1
    function automatic logic [OW-1:0] quarter_sine(input int idx);
        longint u, d, num;
        u   = 2 * longint'(idx) + 1;
        d   = 2 * longint'(DEPTH);
        num = u * (3 * d * d - u * u) * ((longint'(1) << OW) - 1);
        return OW'(num / (2 * d * d * d));
    endfunction

    function automatic logic [PW-1:0] make_phase(input logic s, input logic [AW-1:0] kf);
        return s ? {2'b11, ~kf} : {2'b00, kf};
    endfunction

    logic [OW-1:0] rom [DEPTH];
    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_rom
        assign rom[g] = quarter_sine(g);
    end

    state_t        state, state_d;
    logic          sign, sign_d;
    logic [OW-1:0] mag, mag_d;
    logic [OW-1:0] t, t_d;
    logic [AW-1:0] k, k_d;
    logic [BW-1:0] b, b_d;
    logic [PW-1:0] phase_d;
    logic          valid_d;
    logic          busy_d;

    logic [OW:0]   abs_val;
    logic [AW-1:0] probe;
    logic          hit;

    assign abs_val = i_val[OW] ? (OW + 1)'(~i_val + 1'b1) : i_val;
    assign probe   = k | (AW'(1) << b);
    assign hit     = (t <= mag);

`ifdef QUARTER_WAVE_ARCSINE_ROUND_EN
    logic [OW-1:0]        tk, tk_d;
    logic signed [OW+1:0] dist_up, dist_dn;
    // dist_dn goes negative when mag sits below table[0]; that case must keep k=0
    assign dist_up = $signed({2'b00, t})   - $signed({2'b00, mag});
    assign dist_dn = $signed({2'b00, mag}) - $signed({2'b00, tk});
`endif

    always_comb begin
        state_d = state;
        sign_d  = sign;
        mag_d   = mag;
        t_d     = t;
        k_d     = k;
        b_d     = b;
        phase_d = o_phase;
        valid_d = 1'b0;
`ifdef QUARTER_WAVE_ARCSINE_ROUND_EN
        tk_d    = tk;
`endif
        case (state)
            IDLE: begin
                if (i_valid) begin
                    sign_d  = i_val[OW];
                    mag_d   = abs_val[OW] ? '1 : abs_val[OW-1:0];
                    k_d     = '0;
                    b_d     = BW'(AW - 1);
`ifdef QUARTER_WAVE_ARCSINE_ROUND_EN
                    tk_d    = rom[0];
`endif
                    state_d = READ;
                end
            end
            READ: begin
                t_d     = rom[probe];
                state_d = CMP;
            end
            CMP: begin
                if (hit) begin
                    k_d = probe;
`ifdef QUARTER_WAVE_ARCSINE_ROUND_EN
                    tk_d = t;
`endif
                end
                if (b != '0) begin
                    b_d     = b - 1'b1;
                    state_d = READ;
                end else begin
`ifdef QUARTER_WAVE_ARCSINE_ROUND_EN
                    if (k_d != KMAX) begin
                        state_d = RREAD;
                    end else begin
                        phase_d = make_phase(sign, k_d);
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end
`else
                    phase_d = make_phase(sign, k_d);
                    valid_d = 1'b1;
                    state_d = IDLE;
`endif
                end
            end
`ifdef QUARTER_WAVE_ARCSINE_ROUND_EN
            RREAD: begin
                t_d     = rom[k + 1'b1];
                state_d = RCMP;
            end
            RCMP: begin
                // strict compare so ties keep the lower index
                if (dist_up < dist_dn) k_d = k + 1'b1;
                phase_d = make_phase(sign, k_d);
                valid_d = 1'b1;
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= IDLE;
            sign    <= 1'b0;
            mag     <= '0;
            t       <= '0;
            k       <= '0;
            b       <= '0;
            o_phase <= '0;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
`ifdef QUARTER_WAVE_ARCSINE_ROUND_EN
            tk      <= '0;
`endif
        end else if (i_ce) begin
            state   <= state_d;
            sign    <= sign_d;
            mag     <= mag_d;
            t       <= t_d;
            k       <= k_d;
            b       <= b_d;
            o_phase <= phase_d;
            o_valid <= valid_d;
            o_busy  <= busy_d;
`ifdef QUARTER_WAVE_ARCSINE_ROUND_EN
            tk      <= tk_d;
`endif
        end
    end

endmodule

// File: tb/tb_quarter_wave_arcsine.sv
// Bench for quarter_wave_arcsine: directed corner cases plus random samples against a table-scan model.
module tb_quarter_wave_arcsine;

    localparam int OW = 16;
    localparam int PW = 12;
    localparam int AW = PW - 2;
    localparam int N  = 1 << AW;
`ifdef QUARTER_WAVE_ARCSINE_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce = 1'b1;
    logic          vin = 1'b0;
    logic [OW:0]   val = '0;
    logic          busy, vout;
    logic [PW-1:0] phase;

    int tests = 0;
    int fails = 0;
    int tab [N];

    quarter_wave_arcsine #(.OW(OW), .PW(PW)) dut (
        .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_valid(vin), .i_val(val),
        .o_busy(busy), .o_valid(vout), .o_phase(phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Largest index with table <= |v| (saturated), optionally snapped to the nearer neighbour
    task automatic model(input int v, output logic [31:0] ph, output int lat);
        int m, k;
        bit s;
        s = (v < 0);
        m = s ? -v : v;
        if (m > (1 << OW) - 1) m = (1 << OW) - 1;
        k = 0;
        for (int j = N - 1; j >= 0; j--) begin
            if (tab[j] <= m) begin
                k = j;
                break;
            end
        end
        lat = 2 * AW;
        if (RND && k < N - 1) begin
            lat += 2;
            if (tab[k+1] - m < m - tab[k]) k++;
        end
        ph = s ? 32'('hC00 + (N - 1 - k)) : 32'(k);
    endtask

    task automatic start(input int v);
        val = (OW + 1)'(v);
        vin = 1'b1;
        tick();
        vin = 1'b0;
    endtask

    // Edges from acceptance to the result strobe, -1 on timeout; optional i_ce gap
    task automatic wait_result(input int gap_at, input int gap_len, output int n, output int busy_low);
        bit done;
        done = 1'b0;
        n = 0;
        busy_low = 0;
        while (!done && n < 100) begin
            ce = !(n >= gap_at && n < gap_at + gap_len);
            tick();
            n++;
            done = vout;
            if (!done && !busy) busy_low++;
        end
        ce = 1'b1;
        if (!done) n = -1;
    endtask

    task automatic run_check(input string tag, input int v);
        logic [31:0] ph;
        int lat, n, bl;
        model(v, ph, lat);
        start(v);
        check({tag, "_busy_up"}, 32'(busy), 32'd1);
        wait_result(1000, 0, n, bl);
        check({tag, "_latency"}, 32'(n), 32'(lat));
        check({tag, "_phase"}, 32'(phase), ph);
        check({tag, "_busy_gap"}, 32'(bl), 32'd0);
        check({tag, "_busy_down"}, 32'(busy), 32'd0);
    endtask

    task automatic count_strobes(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (vout) cnt++;
        end
    endtask

    initial begin
        logic [31:0] ph;
        int lat, n, bl, cnt, v, j;

        for (int i = 0; i < N; i++) begin
            longint u;
            u = 2 * i + 1;
            tab[i] = int'((longint'(65535) * u * (longint'(3) * 2048 * 2048 - u * u))
                          / (longint'(2) * 2048 * 2048 * 2048));
        end

        tick(); tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(vout), 32'd0);
        check("reset_phase", 32'(phase), 32'd0);
        rst = 1'b0;
        tick();

        run_check("pos_512", tab[512]);
        check("pos_512_const", 32'(phase), 32'h200);
        tick();
        check("valid_one_cycle", 32'(vout), 32'd0);
        check("phase_held", 32'(phase), 32'h200);

        run_check("neg_512", -tab[512]);
        check("neg_512_const", 32'(phase), 32'hDFF);
        run_check("pos_full", 65535);
        check("pos_full_const", 32'(phase), 32'h3FF);
        run_check("neg_sat", -65536);
        check("neg_sat_const", 32'(phase), 32'hC00);
        run_check("zero", 0);
        check("zero_const", 32'(phase), 32'h000);

        // Request during a search is dropped, not queued
        model(tab[200] + 5, ph, lat);
        start(tab[200] + 5);
        for (int i = 0; i < 4; i++) tick();
        val = (OW + 1)'(-tab[700]);
        vin = 1'b1;
        tick();
        vin = 1'b0;
        wait_result(1000, 0, n, bl);
        check("ignore_latency", 32'(n + 5), 32'(lat));
        check("ignore_phase", 32'(phase), ph);
        count_strobes(40, cnt);
        check("ignore_no_second", 32'(cnt), 32'd0);

        // Back-to-back: new request on the edge right after the strobe
        run_check("b2b_first", tab[40]);
        model(-tab[41], ph, lat);
        start(-tab[41]);
        check("b2b_accept", 32'(busy), 32'd1);
        wait_result(1000, 0, n, bl);
        check("b2b_spacing", 32'(n + 1), 32'(lat + 1));
        check("b2b_phase", 32'(phase), ph);

        // Clock-enable gap stretches latency by exactly its length
        model(tab[300] + 2, ph, lat);
        start(tab[300] + 2);
        wait_result(4, 7, n, bl);
        check("ce_gap_latency", 32'(n), 32'(lat + 7));
        check("ce_gap_phase", 32'(phase), ph);

        // Asynchronous reset mid-search
        start(-tab[900]);
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(vout), 32'd0);
        check("abort_phase", 32'(phase), 32'd0);
        tick();
        rst = 1'b0;
        count_strobes(40, cnt);
        check("abort_no_strobe", 32'(cnt), 32'd0);

`ifdef QUARTER_WAVE_ARCSINE_ROUND_EN
        run_check("round_up", tab[100] + ((tab[101] - tab[100]) / 2) + 1);
        check("round_up_const", 32'(phase), 32'h065);
        run_check("round_keep", tab[100] + 1);
        check("round_keep_const", 32'(phase), 32'h064);
`endif

        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) begin
                v = int'($urandom_range(131071)) - 65536;
            end else begin
                j = int'($urandom_range(N - 1));
                v = tab[j] + int'($urandom_range(2)) - 1;
                if (v > 65535) v = 65535;
                if ($urandom_range(1) == 1) v = -v;
            end
            model(v, ph, lat);
            start(v);
            wait_result(1000, 0, n, bl);
            check($sformatf("rand%0d_latency", i), 32'(n), 32'(lat));
            check($sformatf("rand%0d_phase", i), 32'(phase), ph);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
